remote_jtag_shift_ctrl: RTL and testbench
=========================================

Name: remote_jtag_shift_ctrl

Overview:
Sequences the remote-debug JTAG port toward the PR region: drives o_sr2pr_tck/tckena/tms/tdi and captures i_pr2sr_tdo.
- Accepts one shift command (up to 32 TMS/TDI bit pairs), generates a divided TCK, and shifts the pairs LSB-first.
- Captures TDO on each TCK cycle and returns it as a response.
- Sits between the CSR-facing command source (MMIO register shim) and the SR-to-PR JTAG pins. Replaces free-running TCK gating with software-sequenced transactions.

Parameters:
TCK_DIV, 2, clk cycles per TCK half-period; legal 1..255.
MAX_LEN, 32, max bits per command; fixed at 32, width of the vector fields.

Ports:
clk  in  1  block clock (100 MHz domain).
rst  in  1  synchronous reset, active-high.
cmd_valid  in  1  command offered.
cmd_ready  out  1  controller can accept a command.
cmd_len  in  6  number of bits to shift; legal 1..32.
cmd_tms  in  32  TMS bits; bit 0 is shifted first.
cmd_tdi  in  32  TDI bits; bit 0 is shifted first.
abort  in  1  single-cycle abort request.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed.
rsp_tdo  out  32  captured TDO; bit i = TDO of shift i; bits >= len are 0.
rsp_err  out  1  command rejected (illegal length).
rsp_aborted  out  1  shift terminated by abort.
o_sr2pr_tck  out  1  JTAG clock.
o_sr2pr_tckena  out  1  TCK enable; high for the whole shift.
o_sr2pr_tms  out  1  JTAG TMS.
o_sr2pr_tdi  out  1  JTAG TDI.
i_pr2sr_tdo  in  1  JTAG TDO from the PR region.
busy  out  1  state != IDLE.

Behaviour:
- Reset: every output is 0 except cmd_ready=1. rsp_tdo=0. State=IDLE. Counters=0. Reset mid-shift also forces TCK=0 and tckena=0 on the next edge; no response is generated.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- States: IDLE, TCK_LO, TCK_HI, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch len/tms/tdi and set bit_idx=0.
  - If len is 0 or >32: go to RESP with rsp_err=1 and rsp_tdo=0; no TCK activity.
  - Otherwise go to TCK_LO.
- TCK_LO:
  - tck=0, tckena=1, tms=cmd_tms[bit_idx], tdi=cmd_tdi[bit_idx].
  - Lasts exactly TCK_DIV cycles, counted by div_cnt, then go to TCK_HI.
  - TMS/TDI change only on entry to TCK_LO, so they are stable across the TCK rising edge.
- TCK_HI:
  - tck=1. TMS/TDI are held.
  - Lasts TCK_DIV cycles.
  - On its last cycle, capture i_pr2sr_tdo into tdo_sh[bit_idx].
  - If bit_idx==len-1, go to RESP. Otherwise increment bit_idx and go to TCK_LO.
- RESP:
  - tck=0, tckena=0, tms=0, tdi=0, rsp_valid=1.
  - Hold the response until rsp_ready, then go to IDLE. cmd_ready=0 while in RESP.
- Latency: the command is accepted on edge 0. rsp_valid rises on the cycle 2*TCK_DIV*len+1 after acceptance. Response-side backpressure does not stretch TCK.
- abort in TCK_LO or TCK_HI:
  - Next cycle: tck=0, tckena=0, go to RESP.
  - rsp_aborted=1. rsp_tdo holds only the bits captured so far; the rest are 0.
- abort in IDLE or RESP is ignored.
- Simultaneous abort and the final TDO capture: abort wins, so rsp_aborted=1 and that last bit is discarded.
- div_cnt is 8 bits and reloads to TCK_DIV-1 on each phase entry. bit_idx is 5 bits. Neither wraps in normal operation.

Decomposition:
- Package remote_stp_pkg holds:
  - typedef jtag_state_e (IDLE, TCK_LO, TCK_HI, RESP);
  - localparam JTAG_MAX_LEN=32 and JTAG_LEN_W=6;
  - a packed struct jtag_cmd_t {len, tms, tdi}.
- One sub-module is natural: remote_jtag_tck_div. It is a half-period counter emitting a phase_done pulse and is reused by any future TCK-rate logic.

Test Plan:
- TCK_DIV=2, len=4, tms=0x5, tdi=0xA, TDO stub returns 1,0,1,1 -> tck period 4 clk; tms seq 1,0,1,0; tdi seq 0,1,0,1; rsp_valid at cycle 17; rsp_tdo=0x0000000D; tckena high cycles 1..16.
- len=0, then len=33 -> immediate RESP with rsp_err=1, rsp_tdo=0, tck never toggles, tckena stays 0.
- len=32, TDO tied to tdi (loopback), tdi=0xDEADBEEF -> rsp_tdo=0xDEADBEEF; rsp_valid at cycle 129.
- len=8, abort asserted during the 3rd TCK_HI -> next cycle tck=0 and tckena=0; rsp_aborted=1; only bits 0-1 valid; bits 2-31 = 0.
- rsp_ready held low 10 cycles after response -> rsp_valid, rsp_tdo stable; cmd_ready=0; a new cmd_valid is not accepted until the cycle after the rsp handshake.
- rst asserted mid TCK_HI -> next cycle all outputs 0, cmd_ready=1, no response; a subsequent command behaves identically to after power-on.

Source files
------------

// File: rtl/remote_jtag_shift_ctrl_pkg.sv
// Shared types for the remote-debug JTAG shift controller.
// Holds the FSM state encoding, command record and length legality rule.
package remote_stp_pkg;

  localparam int JTAG_MAX_LEN = 32;
  localparam int JTAG_LEN_W   = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TCK_LO = 2'd1,
    TCK_HI = 2'd2,
    RESP   = 2'd3
  } jtag_state_e;

  typedef struct packed {
    logic [JTAG_LEN_W-1:0]   len;
    logic [JTAG_MAX_LEN-1:0] tms;
    logic [JTAG_MAX_LEN-1:0] tdi;
  } jtag_cmd_t;

  // A shift length is usable only when it is 1..max_len.
  function automatic logic len_legal(input logic [JTAG_LEN_W-1:0] len,
                                     input int unsigned max_len);
    return (len != '0) && (32'(len) <= max_len);
  endfunction

endpackage

// File: rtl/remote_jtag_shift_ctrl_if.sv
// Command/response handshake plus the SR-to-PR JTAG pins of the shift controller.
// master = command source / pin-side model, slave = the controller.
interface remote_jtag_shift_ctrl_if;
  import remote_stp_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [JTAG_LEN_W-1:0]   cmd_len;
  logic [JTAG_MAX_LEN-1:0] cmd_tms;
  logic [JTAG_MAX_LEN-1:0] cmd_tdi;
  logic                    abort;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [JTAG_MAX_LEN-1:0] rsp_tdo;
  logic                    rsp_err;
  logic                    rsp_aborted;
  logic                    o_sr2pr_tck;
  logic                    o_sr2pr_tckena;
  logic                    o_sr2pr_tms;
  logic                    o_sr2pr_tdi;
  logic                    i_pr2sr_tdo;
  logic                    busy;

  modport master (
    output cmd_valid, cmd_len, cmd_tms, cmd_tdi, abort, rsp_ready, i_pr2sr_tdo,
    input  cmd_ready, rsp_valid, rsp_tdo, rsp_err, rsp_aborted,
           o_sr2pr_tck, o_sr2pr_tckena, o_sr2pr_tms, o_sr2pr_tdi, busy
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, abort, rsp_ready, i_pr2sr_tdo,
    output cmd_ready, rsp_valid, rsp_tdo, rsp_err, rsp_aborted,
           o_sr2pr_tck, o_sr2pr_tckena, o_sr2pr_tms, o_sr2pr_tdi, busy
  );

endinterface

// File: rtl/remote_jtag_shift_ctrl_tck_div.sv
// TCK half-period down-counter: reload on phase entry, phase_done_o at terminal count.
// Each phase lasts exactly TCK_DIV clk cycles from the reload edge.
module remote_jtag_tck_div #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic phase_done_o
);

  localparam logic [7:0] RELOAD = 8'(TCK_DIV - 1);

  logic [7:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (load_i) begin
      div_cnt_d = RELOAD;
    end else if (div_cnt_q != 8'd0) begin
      div_cnt_d = div_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= 8'd0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign phase_done_o = (div_cnt_q == 8'd0);

endmodule

// File: rtl/remote_jtag_shift_ctrl.sv
// Software-sequenced JTAG shift controller toward the PR region: one command of
// up to 32 TMS/TDI pairs, LSB first, with TDO captured on each TCK high phase.
//
// state  | meaning
// IDLE   | ready for a command
// TCK_LO | TCK low, TMS/TDI presented for bit_idx
// TCK_HI | TCK high, TDO sampled on the last cycle
// RESP   | response held until rsp_ready
module remote_jtag_shift_ctrl
  import remote_stp_pkg::*;
#(
  parameter int unsigned TCK_DIV = 2,
  parameter int unsigned MAX_LEN = JTAG_MAX_LEN
) (
  input logic                     clk,
  input logic                     rst,
  remote_jtag_shift_ctrl_if.slave bus
);

  jtag_state_e             state_q, state_d;
  jtag_cmd_t               cmd_q, cmd_d;
  logic [4:0]              bit_idx_q, bit_idx_d;
  logic [JTAG_MAX_LEN-1:0] tdo_sh_q, tdo_sh_d;
  logic                    err_q, err_d;
  logic                    aborted_q, aborted_d;
  logic                    phase_done;
  logic                    phase_load;
  logic                    last_bit;
  logic                    shifting;

  logic                    cmd_ready_q, cmd_ready_d;
  logic                    busy_q, busy_d;
  logic                    tck_q, tck_d;
  logic                    tckena_q, tckena_d;
  logic                    tms_q, tms_d;
  logic                    tdi_q, tdi_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [JTAG_MAX_LEN-1:0] rsp_tdo_q, rsp_tdo_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_aborted_q, rsp_aborted_d;

  remote_jtag_tck_div #(
    .TCK_DIV(TCK_DIV)
  ) u_tck_div (
    .clk         (clk),
    .rst         (rst),
    .load_i      (phase_load),
    .phase_done_o(phase_done)
  );

  assign last_bit = ({1'b0, bit_idx_q} == (cmd_q.len - JTAG_LEN_W'(1)));

  // Any transition into a TCK phase restarts the half-period count.
  assign phase_load = ((state_d == TCK_LO) || (state_d == TCK_HI)) && (state_d != state_q);

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      bit_idx_q <= 5'd0;
      tdo_sh_q  <= '0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      bit_idx_q <= bit_idx_d;
      tdo_sh_q  <= tdo_sh_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    cmd_d     = cmd_q;
    bit_idx_d = bit_idx_q;
    tdo_sh_d  = tdo_sh_q;
    err_d     = err_q;
    aborted_d = aborted_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d.len = bus.cmd_len;
          cmd_d.tms = bus.cmd_tms;
          cmd_d.tdi = bus.cmd_tdi;
          bit_idx_d = 5'd0;
          tdo_sh_d  = '0;
          aborted_d = 1'b0;
          err_d     = !len_legal(bus.cmd_len, MAX_LEN);
          state_d   = err_d ? RESP : TCK_LO;
        end
      end
      TCK_LO: begin
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = RESP;
        end else if (phase_done) begin
          state_d = TCK_HI;
        end
      end
      TCK_HI: begin
        // Abort beats a coincident final capture, so that bit is dropped.
        if (bus.abort) begin
          aborted_d = 1'b1;
          state_d   = RESP;
        end else if (phase_done) begin
          tdo_sh_d[bit_idx_q] = bus.i_pr2sr_tdo;
          if (last_bit) begin
            state_d = RESP;
          end else begin
            bit_idx_d = bit_idx_q + 5'd1;
            state_d   = TCK_LO;
          end
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the pins line up with state_q.
  always_comb begin : output_decode
    shifting      = (state_d == TCK_LO) || (state_d == TCK_HI);
    cmd_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    tck_d         = (state_d == TCK_HI);
    tckena_d      = shifting;
    tms_d         = shifting ? cmd_d.tms[bit_idx_d] : 1'b0;
    tdi_d         = shifting ? cmd_d.tdi[bit_idx_d] : 1'b0;
    rsp_valid_d   = (state_d == RESP);
    rsp_tdo_d     = rsp_valid_d ? tdo_sh_d : '0;
    rsp_err_d     = rsp_valid_d && err_d;
    rsp_aborted_d = rsp_valid_d && aborted_d;
  end

  always_ff @(posedge clk) begin : output_reg
    if (rst) begin
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      tck_q         <= 1'b0;
      tckena_q      <= 1'b0;
      tms_q         <= 1'b0;
      tdi_q         <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_tdo_q     <= '0;
      rsp_err_q     <= 1'b0;
      rsp_aborted_q <= 1'b0;
    end else begin
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      tck_q         <= tck_d;
      tckena_q      <= tckena_d;
      tms_q         <= tms_d;
      tdi_q         <= tdi_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_tdo_q     <= rsp_tdo_d;
      rsp_err_q     <= rsp_err_d;
      rsp_aborted_q <= rsp_aborted_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.busy           = busy_q;
  assign bus.o_sr2pr_tck    = tck_q;
  assign bus.o_sr2pr_tckena = tckena_q;
  assign bus.o_sr2pr_tms    = tms_q;
  assign bus.o_sr2pr_tdi    = tdi_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_tdo        = rsp_tdo_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.rsp_aborted    = rsp_aborted_q;

endmodule

// File: tb/tb_remote_jtag_shift_ctrl.sv
// Self-checking bench for remote_jtag_shift_ctrl with a pin-level TDO stub
// and a bit-list reference model of each shift command.
module tb_remote_jtag_shift_ctrl;
  import remote_stp_pkg::*;

  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  remote_jtag_shift_ctrl_if bus();

  remote_jtag_shift_ctrl #(.TCK_DIV(D), .MAX_LEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Pin monitor / TDO stub: records TMS/TDI at each TCK rise and drives TDO.
  int          rise_cnt = 0;
  int          ena_cycles = 0;
  logic        prev_tck = 1'b0;
  logic [63:0] mon_tms = '0;
  logic [63:0] mon_tdi = '0;
  logic        loopback = 1'b0;
  logic [31:0] tdo_pat = '0;

  always @(posedge clk) begin
    #1;
    if (bus.o_sr2pr_tckena) ena_cycles++;
    if (bus.o_sr2pr_tck && !prev_tck) begin
      mon_tms[rise_cnt[5:0]] = bus.o_sr2pr_tms;
      mon_tdi[rise_cnt[5:0]] = bus.o_sr2pr_tdi;
      bus.i_pr2sr_tdo = loopback ? bus.o_sr2pr_tdi : tdo_pat[rise_cnt[4:0]];
      rise_cnt++;
    end
    prev_tck = bus.o_sr2pr_tck;
  end

  function automatic logic [31:0] mask_of(input int n);
    if (n <= 0) return 32'h0;
    if (n >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << n) - 32'h1;
  endfunction

  task automatic clear_mon();
    rise_cnt = 0;
    ena_cycles = 0;
    mon_tms = '0;
    mon_tdi = '0;
  endtask

  task automatic start_cmd(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      checks++; failures++;
      $display("FAIL start_timeout cmd_ready=%b want=1", bus.cmd_ready);
    end
    clear_mon();
    bus.cmd_valid = 1'b1;
    bus.cmd_len = len;
    bus.cmd_tms = tms;
    bus.cmd_tdi = tdi;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic [31:0] tdo, output logic err, output logic ab);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 1000);
    if (!bus.rsp_valid) begin
      checks++; failures++;
      $display("FAIL rsp_timeout rsp_valid=%b want=1", bus.rsp_valid);
    end
    tdo = bus.rsp_tdo;
    err = bus.rsp_err;
    ab = bus.rsp_aborted;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_tdo, bus.rsp_err, bus.rsp_aborted, bus.o_sr2pr_tck,
         bus.o_sr2pr_tckena, bus.o_sr2pr_tms, bus.o_sr2pr_tdi, bus.busy} !== 40'h0) begin
      failures++;
      $display("FAIL reset_outputs rsp_valid=%b tdo=%h tck=%b ena=%b busy=%b want all 0",
               bus.rsp_valid, bus.rsp_tdo, bus.o_sr2pr_tck, bus.o_sr2pr_tckena, bus.busy);
    end
  endtask

  // Shared by the basic scenario and the post-reset rerun.
  task automatic test_basic(input string tag);
    int lat; logic [31:0] tdo; logic err, ab;
    loopback = 1'b0; tdo_pat = 32'h0000_000D;
    start_cmd(6'd4, 32'h5, 32'hA);
    wait_rsp(lat, tdo, err, ab);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL %s_latency got=%0d want=17", tag, lat); end
    checks++;
    if (tdo !== 32'h0000_000D) begin failures++; $display("FAIL %s_tdo got=%h want=0000000d", tag, tdo); end
    checks++;
    if ({err, ab} !== 2'b00) begin failures++; $display("FAIL %s_flags got=%b want=00", tag, {err, ab}); end
    checks++;
    if (ena_cycles !== 16 || rise_cnt !== 4) begin
      failures++; $display("FAIL %s_tck ena=%0d rises=%0d want 16/4", tag, ena_cycles, rise_cnt);
    end
    checks++;
    if (mon_tms[3:0] !== 4'h5 || mon_tdi[3:0] !== 4'hA) begin
      failures++; $display("FAIL %s_pins tms=%h tdi=%h want 5/a", tag, mon_tms[3:0], mon_tdi[3:0]);
    end
    handshake();
  endtask

  task automatic test_illegal_len();
    int lat; logic [31:0] tdo; logic err, ab;
    logic [5:0] lens [3];
    lens[0] = 6'd0; lens[1] = 6'd33; lens[2] = 6'($urandom_range(34, 63));
    for (int i = 0; i < 3; i++) begin
      start_cmd(lens[i], $urandom, $urandom);
      wait_rsp(lat, tdo, err, ab);
      checks++;
      if (lat !== 1 || err !== 1'b1 || ab !== 1'b0 || tdo !== 32'h0) begin
        failures++;
        $display("FAIL illegal_len len=%0d lat=%0d err=%b ab=%b tdo=%h want 1/1/0/0", lens[i], lat, err, ab, tdo);
      end
      checks++;
      if (rise_cnt !== 0 || ena_cycles !== 0) begin
        failures++; $display("FAIL illegal_tck rises=%0d ena=%0d want 0/0", rise_cnt, ena_cycles);
      end
      handshake();
    end
  endtask

  task automatic test_loopback32();
    int lat; logic [31:0] tdo; logic err, ab;
    loopback = 1'b1;
    start_cmd(6'd32, $urandom, 32'hDEAD_BEEF);
    wait_rsp(lat, tdo, err, ab);
    checks++;
    if (lat !== 129) begin failures++; $display("FAIL loop32_latency got=%0d want=129", lat); end
    checks++;
    if (tdo !== 32'hDEAD_BEEF) begin failures++; $display("FAIL loop32_tdo got=%h want=deadbeef", tdo); end
    handshake();
    loopback = 1'b0;
  endtask

  task automatic test_random();
    int lat; logic [31:0] tdo; logic err, ab;
    for (int it = 0; it < 8; it++) begin
      int len = $urandom_range(1, 32);
      logic [31:0] tms = $urandom;
      logic [31:0] tdi = $urandom;
      logic [31:0] exp;
      loopback = ($urandom_range(0, 1) == 1);
      tdo_pat = $urandom;
      exp = (loopback ? tdi : tdo_pat) & mask_of(len);
      start_cmd(6'(len), tms, tdi);
      wait_rsp(lat, tdo, err, ab);
      checks++;
      if (lat !== 2 * D * len + 1 || tdo !== exp || {err, ab} !== 2'b00) begin
        failures++;
        $display("FAIL random len=%0d lat=%0d tdo=%h flags=%b want %0d/%h/00", len, lat, tdo, {err, ab}, 2 * D * len + 1, exp);
      end
      checks++;
      if (rise_cnt !== len || mon_tms[31:0] !== (tms & mask_of(len)) || mon_tdi[31:0] !== (tdi & mask_of(len))) begin
        failures++;
        $display("FAIL random_pins rises=%0d tms=%h tdi=%h want %0d/%h/%h", rise_cnt, mon_tms[31:0], mon_tdi[31:0],
                 len, tms & mask_of(len), tdi & mask_of(len));
      end
      handshake();
    end
  endtask

  // Abort raised in the r-th TCK_HI; late=1 aims it at that phase's capture edge.
  task automatic test_abort();
    int len_t [3]; int r_t [3]; int late_t [3];
    len_t[0] = 8; r_t[0] = 3; late_t[0] = 0;
    len_t[1] = $urandom_range(2, 32); r_t[1] = $urandom_range(1, len_t[1]); late_t[1] = 1;
    len_t[2] = $urandom_range(1, 32); r_t[2] = len_t[2]; late_t[2] = 1;
    loopback = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      tdo_pat = $urandom;
      start_cmd(6'(len_t[i]), $urandom, $urandom);
      while (rise_cnt < r_t[i] && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (late_t[i] != 0) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checks++;
      if (bus.o_sr2pr_tck !== 1'b0 || bus.o_sr2pr_tckena !== 1'b0 || bus.rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL abort_pins tck=%b ena=%b rsp_valid=%b want 0/0/1", bus.o_sr2pr_tck, bus.o_sr2pr_tckena, bus.rsp_valid);
      end
      checks++;
      if (bus.rsp_aborted !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_tdo !== (tdo_pat & mask_of(r_t[i] - 1))) begin
        failures++;
        $display("FAIL abort_rsp len=%0d r=%0d ab=%b err=%b tdo=%h want 1/0/%h", len_t[i], r_t[i],
                 bus.rsp_aborted, bus.rsp_err, bus.rsp_tdo, tdo_pat & mask_of(r_t[i] - 1));
      end
      handshake();
    end
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL abort_idle busy=%b rsp_valid=%b want 0/0", bus.busy, bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] tdo, tdo2; logic err, ab;
    int bad = 0;
    loopback = 1'b0; tdo_pat = $urandom;
    start_cmd(6'd5, $urandom, $urandom);
    wait_rsp(lat, tdo, err, ab);
    bus.cmd_valid = 1'b1; bus.cmd_len = 6'd3; bus.cmd_tms = $urandom; bus.cmd_tdi = $urandom;
    for (int c = 0; c < 10; c++) begin
      bus.abort = (c == 4);
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_tdo !== (tdo_pat & mask_of(5)) ||
          bus.cmd_ready !== 1'b0 || bus.rsp_aborted !== 1'b0) bad++;
    end
    bus.abort = 1'b0;
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL backpressure_hold bad_cycles=%0d want=0", bad); end
    clear_mon();
    tdo_pat = $urandom;
    handshake();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_after_hs rsp_valid=%b cmd_ready=%b busy=%b want 0/1/0", bus.rsp_valid, bus.cmd_ready, bus.busy);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_rsp(lat, tdo2, err, ab);
    checks++;
    if (lat !== 13 || tdo2 !== (tdo_pat & mask_of(3))) begin
      failures++; $display("FAIL b2b_second lat=%0d tdo=%h want 13/%h", lat, tdo2, tdo_pat & mask_of(3));
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bad_rsp_check: begin end
    loopback = 1'b0; tdo_pat = $urandom;
    start_cmd(6'd8, $urandom, $urandom);
    while (rise_cnt < 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.o_sr2pr_tck !== 1'b0 || bus.o_sr2pr_tckena !== 1'b0 ||
        bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp_tdo !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid cmd_ready=%b tck=%b ena=%b rsp_valid=%b busy=%b tdo=%h want 1/0/0/0/0/0",
               bus.cmd_ready, bus.o_sr2pr_tck, bus.o_sr2pr_tckena, bus.rsp_valid, bus.busy, bus.rsp_tdo);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_no_rsp rsp_valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
    end
    test_basic("post_reset");
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_len = '0; bus.cmd_tms = '0; bus.cmd_tdi = '0;
    bus.abort = 1'b0; bus.rsp_ready = 1'b0; bus.i_pr2sr_tdo = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic("basic");
    test_illegal_len();
    test_loopback32();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
